// File: rtl/pwm_capture_if.sv
// Register-side bundle of the PWM capture block: PWM inputs, per-channel
// enables, the shared prescaler, and the per-channel measurement results.
interface pwm_capture_if #(
  parameter int NCH = 3
);
  logic [NCH-1:0]         pwm_i;
  logic [NCH-1:0]         enable_i;
  logic [31:0]            prescaler_i;
  logic [NCH-1:0][31:0]   period_o;
  logic [NCH-1:0][31:0]   duty_o;
  logic [NCH-1:0]         valid_o;
  logic [NCH-1:0]         timeout_o;

  modport master (
    output pwm_i, enable_i, prescaler_i,
    input  period_o, duty_o, valid_o, timeout_o
  );
  modport slave (
    input  pwm_i, enable_i, prescaler_i,
    output period_o, duty_o, valid_o, timeout_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: per-channel period and high-time measurement in prescaled
// ticks, with a one-cycle valid strobe per capture and a sticky timeout flag.
module pwm_capture_ch #(
  parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pwm_i,
  input  logic        en_i,
  input  logic        tick_i,
  output logic [31:0] period_o,
  output logic [31:0] duty_o,
  output logic        valid_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  state_e      state_q, state_d;
  logic        s1_q, sync_q, prev_q;
  logic [31:0] per_q, per_d, hi_q, hi_d;
  logic [31:0] period_q, period_d, duty_q, duty_d;
  logic        valid_q, valid_d, to_q, to_d;
  logic        rise;

  assign rise = sync_q & ~prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= pwm_i;
      sync_q   <= s1_q;
      prev_q   <= sync_q;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    to_d     = to_q;
    if (!en_i) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      to_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          per_d   = '0;
          hi_d    = '0;
        end
        ARM: if (rise) begin
          state_d = MEAS;
          per_d   = {31'b0, tick_i};
          hi_d    = {31'b0, tick_i};
        end
        MEAS: begin
          // A rise always wins over a timeout landing in the same cycle.
          if (rise) begin
            period_d = per_q;
            duty_d   = hi_q;
            valid_d  = 1'b1;
            to_d     = 1'b0;
            per_d    = {31'b0, tick_i};
            hi_d     = {31'b0, tick_i};
          end else if (tick_i) begin
            if (per_q == TIMEOUT) begin
              to_d    = 1'b1;
              state_d = ARM;
              per_d   = '0;
              hi_d    = '0;
            end else begin
              per_d = per_q + 32'd1;
              hi_d  = hi_q + {31'b0, sync_q};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period_o  = period_q;
  assign duty_o    = duty_q;
  assign valid_o   = valid_q;
  assign timeout_o = to_q;
endmodule

module pwm_capture #(
  parameter int          NCH     = 3,
  parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  pwm_capture_if.slave  bus
);
  logic [31:0]          cnt_q, cnt_d;
  logic                 tick;
  logic [NCH-1:0][31:0] per_w, duty_w;
  logic [NCH-1:0]       val_w, to_w;

  // Shared prescaler; a prescaler drop below cnt wraps through 2^32.
  assign tick = (cnt_q == bus.prescaler_i);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (~|bus.enable_i || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    pwm_capture_ch #(.TIMEOUT(TIMEOUT)) u_ch (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .pwm_i     (bus.pwm_i[n]),
      .en_i      (bus.enable_i[n]),
      .tick_i    (tick),
      .period_o  (per_w[n]),
      .duty_o    (duty_w[n]),
      .valid_o   (val_w[n]),
      .timeout_o (to_w[n])
    );
  end

  assign bus.period_o  = per_w;
  assign bus.duty_o    = duty_w;
  assign bus.valid_o   = val_w;
  assign bus.timeout_o = to_w;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed capture values.
module tb_pwm_capture;
  localparam int NCH = 3;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture_if #(.NCH(NCH)) bus ();
  pwm_capture #(.NCH(NCH), .TIMEOUT(32'(TMO))) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int vectors = 0;
  int fails   = 0;

  // Waveform generators: periodic (gen_on) or a static level.
  int gen_per[NCH], gen_hi[NCH], gen_t0[NCH];
  bit gen_on[NCH], lvl[NCH];
  int ncyc = 0;

  initial begin
    logic [NCH-1:0] v;
    v = '0;
    bus.pwm_i = '0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < NCH; n++)
        if (gen_on[n]) v[n] = ((ncyc - gen_t0[n]) % gen_per[n]) < gen_hi[n];
        else           v[n] = lvl[n];
      bus.pwm_i = v;
      ncyc++;
    end
  end

  // Reference model: a capture is the number of ticks (and high ticks) that
  // fell in the cycles from one rise up to, but excluding, the next one.
  int          md[NCH];               // 0 idle, 1 waiting for rise, 2 measuring
  longint      tc, kk;                // ticks so far, cycles since prescaler restart
  longint      hc[NCH], cs[NCH], hs[NCH];
  logic [NCH-1:0] h1, h2, h3;
  longint      e_per[NCH], e_duty[NCH];
  bit          e_val[NCH], e_to[NCH];

  task automatic model_reset();
    tc = 0; kk = 0; h1 = '0; h2 = '0; h3 = '0;
    for (int n = 0; n < NCH; n++) begin
      md[n] = 0; hc[n] = 0; cs[n] = 0; hs[n] = 0;
      e_per[n] = 0; e_duty[n] = 0; e_val[n] = 0; e_to[n] = 0;
    end
  endtask

  task automatic model_step();
    longint p;
    bit     tk, r;
    p  = longint'(bus.prescaler_i);
    tk = (kk % (p + 1)) == p;
    for (int n = 0; n < NCH; n++) begin
      r = h2[n] & ~h3[n];
      e_val[n] = 0;
      if (!bus.enable_i[n]) begin
        md[n] = 0; e_to[n] = 0;
      end else if (md[n] == 0) begin
        md[n] = 1;
      end else if (md[n] == 1) begin
        if (r) begin md[n] = 2; cs[n] = tc; hs[n] = hc[n]; end
      end else if (r) begin
        e_per[n] = tc - cs[n]; e_duty[n] = hc[n] - hs[n];
        e_val[n] = 1; e_to[n] = 0; cs[n] = tc; hs[n] = hc[n];
      end else if (tk && (tc - cs[n]) == TMO) begin
        e_to[n] = 1; md[n] = 1;
      end
    end
    for (int n = 0; n < NCH; n++) if (tk && h2[n]) hc[n]++;
    if (tk) tc++;
    kk = (|bus.enable_i) ? kk + 1 : 0;
    h3 = h2; h2 = h1; h1 = bus.pwm_i;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [63:0] act, input int lo, input int hi);
    vectors++;
    if (act < 64'(lo) || act > 64'(hi)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else begin
        model_step();
        #1;
        for (int n = 0; n < NCH; n++) begin
          chk($sformatf("ch%0d period", n), {32'b0, bus.period_o[n]}, e_per[n]);
          chk($sformatf("ch%0d duty", n), {32'b0, bus.duty_o[n]}, e_duty[n]);
          chk($sformatf("ch%0d valid", n), {63'b0, bus.valid_o[n]}, {63'b0, e_val[n]});
          chk($sformatf("ch%0d timeout", n), {63'b0, bus.timeout_o[n]}, {63'b0, e_to[n]});
        end
      end
    end
  endtask

  task automatic wait_out(input bit is_to, input int ch, input int maxc, input string nm);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk); #1;
      seen = is_to ? bus.timeout_o[ch] : bus.valid_o[ch];
    end
    vectors++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no event within %0d cycles, expected one", nm, maxc);
    end
  endtask

  task automatic hold_lvl(input int ch, input bit v, input int cycles);
    @(posedge clk); #1;
    gen_on[ch] = 0; lvl[ch] = v;
    repeat (cycles - 1) @(posedge clk);
  endtask

  task automatic set_gen(input int ch, input int per, input int hi);
    gen_per[ch] = per; gen_hi[ch] = hi; gen_t0[ch] = ncyc; gen_on[ch] = 1;
  endtask

  task automatic chk_zero(input string nm);
    for (int n = 0; n < NCH; n++) begin
      chk($sformatf("%s period%0d", nm, n), {32'b0, bus.period_o[n]}, 0);
      chk($sformatf("%s duty%0d", nm, n), {32'b0, bus.duty_o[n]}, 0);
    end
    chk({nm, " valid"}, {61'b0, bus.valid_o}, 0);
    chk({nm, " timeout"}, {61'b0, bus.timeout_o}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.enable_i = '0;
    bus.prescaler_i = '0;
    for (int n = 0; n < NCH; n++) begin
      gen_on[n] = 0; lvl[n] = 0; gen_per[n] = 10; gen_hi[n] = 1; gen_t0[n] = 0;
    end
    model_reset();
    fork compare_loop(); join_none

    #3 chk_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Channel 0, no prescaling, 10/3
    @(negedge clk) bus.enable_i = 3'b001;
    @(posedge clk); #1 set_gen(0, 10, 3);
    wait_out(0, 0, 40, "t1 first valid");
    chk("t1 period", {32'b0, bus.period_o[0]}, 10);
    chk("t1 duty", {32'b0, bus.duty_o[0]}, 3);
    t = cyc;
    wait_out(0, 0, 15, "t1 second valid");
    chk("t1 valid spacing", 64'(cyc - t), 10);

    // Channel 1, prescaler 1, 20/6 -> 10/3 ticks
    @(negedge clk) begin bus.enable_i = '0; bus.prescaler_i = 32'd1; end
    repeat (2) @(negedge clk);
    bus.enable_i = 3'b010;
    @(posedge clk); #1 set_gen(1, 20, 6);
    wait_out(0, 1, 80, "t2 valid");
    chk_rng("t2 period", {32'b0, bus.period_o[1]}, 9, 11);
    chk_rng("t2 duty", {32'b0, bus.duty_o[1]}, 2, 4);

    // Channel 2: one rise then held high -> timeout, then recovery
    @(negedge clk) begin bus.enable_i = '0; bus.prescaler_i = '0; end
    repeat (2) @(negedge clk);
    bus.enable_i = 3'b100;
    hold_lvl(2, 0, 5);
    hold_lvl(2, 1, 1);
    t = cyc;
    wait_out(1, 2, 150, "t3 timeout");
    chk("t3 timeout latency", 64'(cyc - t), 103);
    chk("t3 no valid", {63'b0, bus.valid_o[2]}, 0);
    hold_lvl(2, 0, 5);
    hold_lvl(2, 1, 7);
    hold_lvl(2, 0, 4);
    hold_lvl(2, 1, 1);
    wait_out(0, 2, 10, "t3 valid");
    chk("t3 period", {32'b0, bus.period_o[2]}, 11);
    chk("t3 duty", {32'b0, bus.duty_o[2]}, 7);
    chk("t3 timeout cleared", {63'b0, bus.timeout_o[2]}, 0);

    // Channels 0 and 1 with identical waveforms
    @(negedge clk) bus.enable_i = '0;
    hold_lvl(0, 0, 1);
    hold_lvl(1, 0, 4);
    @(negedge clk) bus.enable_i = 3'b011;
    @(posedge clk); #1 begin set_gen(0, 12, 5); set_gen(1, 12, 5); end
    wait_out(0, 0, 40, "t4 valid");
    chk("t4 valid pair", {62'b0, bus.valid_o[1:0]}, 3);
    chk("t4 period0", {32'b0, bus.period_o[0]}, 12);
    chk("t4 period1", {32'b0, bus.period_o[1]}, 12);
    chk("t4 duty1", {32'b0, bus.duty_o[1]}, 5);

    // Channel 0 enable dropped for one cycle mid-measurement
    repeat (3) @(posedge clk);
    @(negedge clk) bus.enable_i = 3'b010;
    @(negedge clk) bus.enable_i = 3'b011;
    @(posedge clk); #1;
    chk("t5 period hold", {32'b0, bus.period_o[0]}, 12);
    chk("t5 duty hold", {32'b0, bus.duty_o[0]}, 5);
    wait_out(0, 0, 40, "t5 valid");
    chk("t5 period", {32'b0, bus.period_o[0]}, 12);
    chk("t5 duty", {32'b0, bus.duty_o[0]}, 5);

    // Asynchronous reset while pwm is low, then resume
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (((ncyc - gen_t0[0]) % 12) == 8) break;
    end
    @(negedge clk); #2 rstn = 1'b0;
    #1 chk_zero("t6 async reset");
    @(negedge clk) rstn = 1'b1;
    wait_out(0, 0, 40, "t6 valid");
    chk("t6 period", {32'b0, bus.period_o[0]}, 12);
    chk("t6 duty", {32'b0, bus.duty_o[0]}, 5);
    chk("t6 valid1", {63'b0, bus.valid_o[1]}, 1);

    repeat (3) @(posedge clk);
    #2 $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
